muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, the multi-cycle companion to the single-cycle ALU in the execute stage. Accepts one operation via start/busy handshake, computes over DATA_WIDTH iterations (radix-2 shift-add / restoring divide), and presents a one-cycle valid pulse with the result. Width is parametrised; the op encoding equals the instruction funct3 field for opcode R with funct7 = 7'b0000001.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one
// iteration per cycle, followed by a single sign-fix cycle. Divide-by-zero and
// signed-overflow divides bypass the iteration and complete on the capture edge.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MD_OP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [MD_OP_WIDTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  result_o
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]    MinNeg  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          cnt_q;
  logic [MD_OP_WIDTH-1:0]   op_q;
  logic                     neg_q;
  // Multiplicand for multiply, divisor for divide.
  logic [W-1:0]             opr_q;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*W-1:0]           prod_q;
  logic                     valid_q;
  logic [W-1:0]             result_q;

  logic                     a_sgn, b_sgn, neg_in;
  logic [W-1:0]             a_mag, b_mag;
  logic                     div_zero, div_ovf, fast;
  logic [W-1:0]             fast_res;
  logic [W:0]               mul_sum, div_shift, div_diff;
  logic [2*W-1:0]           iter_next, prod_neg;
  logic [W-1:0]             hi_neg, lo_neg, fix_res;

  // Operand preparation and fast-path detection at capture time.
  always_comb begin
    a_sgn    = a_i[W-1] & ((op_i == 3'b001) || (op_i == 3'b010) ||
                           (op_i == 3'b100) || (op_i == 3'b110));
    b_sgn    = b_i[W-1] & ((op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110));
    a_mag    = a_sgn ? -a_i : a_i;
    b_mag    = b_sgn ? -b_i : b_i;
    // Remainder takes the dividend's sign; everything else the product of signs.
    neg_in   = (op_i[2] && op_i[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = op_i[2] && (b_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (a_i == MinNeg) && (b_i == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op_i[1] ? a_i : '1;
    else          fast_res = op_i[1] ? '0 : a_i;
  end

  // One multiply or divide iteration, plus the final sign fix and selection.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opr_q} : '0);
    div_shift = prod_q[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, opr_q};
    if (!op_q[2])         iter_next = {mul_sum, prod_q[W-1:1]};
    else if (!div_diff[W]) iter_next = {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
    else                  iter_next = {div_shift[W-1:0], prod_q[W-2:0], 1'b0};

    prod_neg = -prod_q;
    hi_neg   = -prod_q[2*W-1:W];
    lo_neg   = -prod_q[W-1:0];
    if (op_q[2]) begin
      if (op_q[1]) fix_res = neg_q ? hi_neg : prod_q[2*W-1:W];
      else         fix_res = neg_q ? lo_neg : prod_q[W-1:0];
    end else if (op_q[1:0] == 2'b00) begin
      fix_res = prod_q[W-1:0];
    end else begin
      fix_res = neg_q ? prod_neg[2*W-1:W] : prod_q[2*W-1:W];
    end
  end

  // Control FSM and datapath registers; flush aborts without touching result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opr_q    <= '0;
      prod_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          valid_q <= 1'b0;
          if (start_i) begin
            op_q  <= op_i;
            neg_q <= neg_in;
            cnt_q <= '0;
            if (fast) begin
              result_q <= fast_res;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end else begin
              opr_q   <= op_i[2] ? b_mag : a_mag;
              prod_q  <= {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
              state_q <= StCalc;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          prod_q <= iter_next;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = (state_q == StCalc) || (state_q == StFix);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes model results and the
// cycle in which valid_o is due; a negedge monitor pops and compares.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  muldiv_unit #(.DATA_WIDTH(32), .MD_OP_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  op;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ready_cyc = 0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from the start-asserted cycle to the valid_o cycle.
  function automatic int latency(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && (b == 32'd0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; optionally record the expected completion.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    exp_t e;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (push) begin
      e.res = ref_model(op, a, b);
      e.cyc = cyc + latency(op, a, b);
      e.op  = op;
      exp_q.push_back(e);
      ready_cyc = e.cyc;
    end
    tick(1);
    start_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_ready();
    while (cyc < ready_cyc) tick(1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: result_o=%h at cycle %0d, no op outstanding",
                 result_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (result_o !== e.res || cyc != e.cyc) begin
          n_err++;
          $display("FAIL op%0d: result_o=%h at cycle %0d, want %h at cycle %0d",
                   e.op, result_o, cyc, e.res, e.cyc);
        end
        last_res = e.res;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          busy_cnt;
    int          guard;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    #12;
    check("reset_result", result_o, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // MUL latency and busy duration.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
    tick(1);

    // Directed arithmetic and fast-path cases, issued as early as allowed.
    wait_ready(); issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_ready(); issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_ready(); issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_ready(); issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_ready(); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_ready(); issue(3'd5, 32'd100, 32'd7, 1'b1);
    wait_ready(); issue(3'd7, 32'd100, 32'd7, 1'b1);
    wait_ready(); issue(3'd5, 32'd100, 32'd0, 1'b1);
    wait_ready(); issue(3'd7, 32'd100, 32'd0, 1'b1);
    wait_ready(); issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_ready(); issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Start while busy is dropped.
    wait_ready(); issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    tick(5);
    issue(3'd4, 32'd50, 32'd5, 1'b0);
    wait_ready();
    tick(3);

    // Flush mid-divide: no valid, result held.
    issue(3'd4, 32'h7654_3210, 32'd13, 1'b0);
    tick(9);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    tick(40);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_result_held", result_o, last_res);

    // Asynchronous reset mid-multiply.
    issue(3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    tick(19);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result", result_o, 32'd0);
    check("async_rst_busy", {31'd0, busy_o}, 32'd0);
    check("async_rst_valid", {31'd0, valid_o}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);

    // Random ops, often back-to-back in the DONE cycle.
    repeat (60) begin
      wait_ready();
      if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2));
      op = 3'($urandom);
      a  = pick_val();
      b  = pick_val();
      issue(op, a, b, 1'b1);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
